// File: rtl/mouse_packet_decoder.sv
// Decodes 3-byte PS/2 mouse packets into screen-clamped absolute pointer coordinates and button levels.
// Define MOUSE_TIMEOUT_EN to compile in the inter-byte timeout that resynchronises a stalled packet.
module mouse_packet_decoder #(
  parameter int X_MAX          = 1023,
  parameter int Y_MAX          = 767,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left_mouse,
  output logic        right_mouse,
  output logic        pkt_valid,
  output logic        sync_err
);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, APPLY} state_t;

  localparam logic [11:0]        X_RESET = 12'(X_MAX / 2);
  localparam logic [11:0]        Y_RESET = 12'(Y_MAX / 2);
  localparam logic signed [13:0] X_LIMIT = 14'(X_MAX);
  localparam logic signed [13:0] Y_LIMIT = 14'(Y_MAX);

  state_t             state_q;
  logic [1:0]         btn_q;
  logic [1:0]         sign_q;
  logic [1:0]         ovf_q;
  logic [7:0]         dxByte_q;
  logic [7:0]         dyByte_q;
  logic [11:0]        xpos_q;
  logic [11:0]        ypos_q;
  logic               left_q;
  logic               right_q;
  logic               pktValid_q;
  logic               syncErr_q;

  logic signed [13:0] dx;
  logic signed [13:0] dy;
  logic signed [13:0] xSum;
  logic signed [13:0] ySum;
  logic [11:0]        xpos_d;
  logic [11:0]        ypos_d;
  logic               byteZeroMode;
  logic               timedOut;

  // Index 0 of sign_q/ovf_q is the X axis, index 1 the Y axis; PS/2 +Y is up, screen Y grows down.
  always_comb begin
    dx   = ovf_q[0] ? 14'sd0 : $signed({{6{sign_q[0]}}, dxByte_q});
    dy   = ovf_q[1] ? 14'sd0 : $signed({{6{sign_q[1]}}, dyByte_q});
    xSum = $signed({2'b00, xpos_q}) + dx;
    ySum = $signed({2'b00, ypos_q}) - dy;

    if (xSum < 14'sd0)
      xpos_d = '0;
    else if (xSum > X_LIMIT)
      xpos_d = X_LIMIT[11:0];
    else
      xpos_d = xSum[11:0];

    if (ySum < 14'sd0)
      ypos_d = '0;
    else if (ySum > Y_LIMIT)
      ypos_d = Y_LIMIT[11:0];
    else
      ypos_d = ySum[11:0];
  end

`ifdef MOUSE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] toCnt_q;

  assign timedOut = ((state_q == WAIT_B1) || (state_q == WAIT_B2)) &&
                    (toCnt_q == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      toCnt_q <= '0;
    else if (!byteZeroMode && !rx_valid)
      toCnt_q <= toCnt_q + 1'b1;
    else
      toCnt_q <= '0;
  end
`else
  // Constant false for any legal configuration; the FSM waits indefinitely mid-packet.
  assign timedOut = (TIMEOUT_CYCLES < 0);
`endif

  // An expired partial packet and the APPLY cycle both treat the incoming byte as a fresh byte0.
  assign byteZeroMode = (state_q == WAIT_B0) || (state_q == APPLY) || timedOut;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_B0;
      btn_q      <= '0;
      sign_q     <= '0;
      ovf_q      <= '0;
      dxByte_q   <= '0;
      dyByte_q   <= '0;
      xpos_q     <= X_RESET;
      ypos_q     <= Y_RESET;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      pktValid_q <= 1'b0;
      syncErr_q  <= 1'b0;
    end else begin
      pktValid_q <= 1'b0;
      syncErr_q  <= 1'b0;

      if (state_q == APPLY) begin
        xpos_q     <= xpos_d;
        ypos_q     <= ypos_d;
        left_q     <= btn_q[0];
        right_q    <= btn_q[1];
        pktValid_q <= 1'b1;
      end

      if (byteZeroMode) begin
        if (rx_valid && rx_data[3]) begin
          btn_q   <= rx_data[1:0];
          sign_q  <= rx_data[5:4];
          ovf_q   <= rx_data[7:6];
          state_q <= WAIT_B1;
        end else begin
          syncErr_q <= rx_valid;
          state_q   <= WAIT_B0;
        end
      end else if (rx_valid) begin
        if (state_q == WAIT_B1) begin
          dxByte_q <= rx_data;
          state_q  <= WAIT_B2;
        end else begin
          dyByte_q <= rx_data;
          state_q  <= APPLY;
        end
      end
    end
  end

  assign xpos        = xpos_q;
  assign ypos        = ypos_q;
  assign left_mouse  = left_q;
  assign right_mouse = right_q;
  assign pkt_valid   = pktValid_q;
  assign sync_err    = syncErr_q;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Self-checking bench for mouse_packet_decoder: directed packets plus randomized byte streams
// compared every cycle against a packet-level reference model.
module tb_mouse_packet_decoder;

  localparam int XM = 1023;
  localparam int YM = 767;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left_mouse;
  logic        right_mouse;
  logic        pkt_valid;
  logic        sync_err;

  int testsRun    = 0;
  int testsFailed = 0;
  int pktCount    = 0;
  int syncCount   = 0;

  always #5 clk = ~clk;

  mouse_packet_decoder #(
    .X_MAX(XM),
    .Y_MAX(YM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .xpos(xpos),
    .ypos(ypos),
    .left_mouse(left_mouse),
    .right_mouse(right_mouse),
    .pkt_valid(pkt_valid),
    .sync_err(sync_err)
  );

  // Reference model: collects bytes of the current packet in a queue, applies a full packet one edge later.
  byte unsigned pktBytes[$];
  byte unsigned pend[3];
  int  idleCnt;
  bit  applyPending;
  bit  mExpired;
  byte unsigned mB0;
  int  mX, mY;
  bit  mL, mR, mPkt, mSync;

  function automatic int clampVal(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(bit ovf, bit sgn, byte unsigned mag);
    if (ovf) return 0;
    return sgn ? int'(mag) - 256 : int'(mag);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mX = XM / 2;
      mY = YM / 2;
      mL = 1'b0;
      mR = 1'b0;
      mPkt = 1'b0;
      mSync = 1'b0;
      pktBytes.delete();
      idleCnt = 0;
      applyPending = 1'b0;
    end else begin
      mPkt = 1'b0;
      mSync = 1'b0;
      if (applyPending) begin
        mB0 = pend[0];
        mX = clampVal(mX + delta(mB0[6], mB0[4], pend[1]), XM);
        mY = clampVal(mY - delta(mB0[7], mB0[5], pend[2]), YM);
        mL = mB0[0];
        mR = mB0[1];
        mPkt = 1'b1;
        applyPending = 1'b0;
      end
      mExpired = 1'b0;
`ifdef MOUSE_TIMEOUT_EN
      mExpired = (pktBytes.size() > 0) && (idleCnt >= TO);
`endif
      if (rx_valid) begin
        idleCnt = 0;
        if (pktBytes.size() == 0 || mExpired) begin
          pktBytes.delete();
          if (rx_data[3]) pktBytes.push_back(rx_data);
          else mSync = 1'b1;
        end else begin
          pktBytes.push_back(rx_data);
          if (pktBytes.size() == 3) begin
            for (int i = 0; i < 3; i++) pend[i] = pktBytes[i];
            applyPending = 1'b1;
            pktBytes.delete();
          end
        end
      end else if (mExpired) begin
        pktBytes.delete();
        idleCnt = 0;
      end else if (pktBytes.size() > 0) begin
        idleCnt++;
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checkOutput("xpos", int'(xpos), mX);
      checkOutput("ypos", int'(ypos), mY);
      checkOutput("left_mouse", int'(left_mouse), int'(mL));
      checkOutput("right_mouse", int'(right_mouse), int'(mR));
      checkOutput("pkt_valid", int'(pkt_valid), int'(mPkt));
      checkOutput("sync_err", int'(sync_err), int'(mSync));
      if (pkt_valid === 1'b1) pktCount++;
      if (sync_err === 1'b1) syncCount++;
    end
  end

  task automatic applyStimulus(input bit v, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    applyStimulus(1'b1, b0);
    applyStimulus(1'b1, b1);
    applyStimulus(1'b1, b2);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #1;
    checkOutput("rst_async_xpos", int'(xpos), 511);
    checkOutput("rst_async_ypos", int'(ypos), 383);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_xpos", int'(xpos), 511);
    checkOutput("rst_ypos", int'(ypos), 383);
    checkOutput("rst_buttons", int'({left_mouse, right_mouse}), 0);
    checkOutput("rst_pulses", int'({pkt_valid, sync_err}), 0);
    rst = 1'b0;
  endtask

  int pk0, sy0;
  logic [7:0] rndData;

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(posedge clk);
    doReset();

    // Left button, dx=+16; pkt_valid exactly one edge after byte2 is sampled.
    pk0 = pktCount;
    sendPacket(8'h09, 8'h10, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("pkt_before_apply", int'(pkt_valid), 0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("pkt_latency", int'(pkt_valid), 1);
    checkOutput("pkt_xpos", int'(xpos), 527);
    idleCycles(2);
    checkOutput("hold_xpos", int'(xpos), 527);
    checkOutput("hold_ypos", int'(ypos), 383);
    checkOutput("left_level", int'(left_mouse), 1);
    checkOutput("one_pulse", pktCount - pk0, 1);

    // Negative deltas on both axes.
    doReset();
    sendPacket(8'h38, 8'hF0, 8'hF0);
    idleCycles(3);
    checkOutput("neg_xpos", int'(xpos), 495);
    checkOutput("neg_ypos", int'(ypos), 399);

    // Back-to-back packets with clamping at X_MAX.
    doReset();
    pk0 = pktCount;
    sendPacket(8'h08, 8'hFF, 8'h00);
    sendPacket(8'h08, 8'hFF, 8'h00);
    sendPacket(8'h08, 8'hFF, 8'h00);
    idleCycles(3);
    checkOutput("b2b_clamp_xpos", int'(xpos), 1023);
    checkOutput("b2b_pulses", pktCount - pk0, 3);

    // Framing error, then X overflow discards dx while dy still applies.
    sy0 = syncCount;
    applyStimulus(1'b1, 8'h00);
    idleCycles(2);
    checkOutput("sync_pulse", syncCount - sy0, 1);
    checkOutput("sync_hold_xpos", int'(xpos), 1023);
    sendPacket(8'h48, 8'h7F, 8'h01);
    idleCycles(3);
    checkOutput("ovf_xpos", int'(xpos), 1023);
    checkOutput("ovf_ypos", int'(ypos), 382);

    // Stalled packet followed by a fresh one.
    doReset();
    pk0 = pktCount;
    sy0 = syncCount;
    applyStimulus(1'b1, 8'h08);
    applyStimulus(1'b1, 8'h05);
    idleCycles(20);
    sendPacket(8'h08, 8'h02, 8'h00);
    idleCycles(3);
    checkOutput("stall_pulses", pktCount - pk0, 1);
`ifdef MOUSE_TIMEOUT_EN
    checkOutput("timeout_xpos", int'(xpos), 513);
    checkOutput("timeout_ypos", int'(ypos), 383);
    checkOutput("timeout_sync", syncCount - sy0, 0);
`else
    checkOutput("stall_xpos", int'(xpos), 516);
    checkOutput("stall_ypos", int'(ypos), 375);
    checkOutput("stall_sync", syncCount - sy0, 2);
`endif

    // Randomized streams with occasional long gaps and one mid-stream reset.
    doReset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      if ($urandom_range(99) < 5) begin
        idleCycles($urandom_range(20, 14));
      end else begin
        rndData = 8'($urandom);
        if ($urandom_range(9) < 7) rndData[3] = 1'b1;
        applyStimulus($urandom_range(3) != 0, rndData);
      end
    end
    idleCycles(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
